// File: rtl/ps2_scancode_receiver_pkg.sv
// Shared definitions for the PS/2 scancode receiver: special codes,
// deframer state encoding and the parity helper.
package ps2_scancode_receiver_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam int         KEY_W     = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  // Odd parity over code plus parity bit: true when the frame is consistent.
  function automatic logic odd_parity_ok(input logic [7:0] code, input logic p);
    return (^code) ^ p;
  endfunction

endpackage

// File: rtl/ps2_scancode_receiver_fifo.sv
// Small show-ahead FIFO holding decoded {break, code} entries.
module scancode_fifo #(
  parameter int DW = 9,
  parameter int AW = 2
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign dout  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; a push into a full FIFO only lands with a pop.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
  end

  // Pointer and count registers.
  always_ff @(posedge Clock or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge Clock) begin
    // NOTE: the array is not reset; empty/count gate its contents, so stale data is never observed.
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard front end: line conditioning, 11-bit frame deframer with
// timeout, break-prefix folding and a small key FIFO for the TEC instruction.
module ps2_scancode_receiver
  import ps2_scancode_receiver_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_AW     = 2,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             PS2_CLK,
  input  logic             PS2_DATA,
  input  logic             iPop,
  input  logic             iClearErr,
  output logic [KEY_W-1:0] oKey,
  output logic             oValid,
  output logic             oParityErr,
  output logic             oFrameErr,
  output logic             oOverflow
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  logic [1:0]            clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic [FILTER_LEN-1:0] clk_shift_q, clk_shift_d, dat_shift_q, dat_shift_d;
  logic                  clk_filt_q, clk_filt_d, dat_filt_q, dat_filt_d;
  logic                  clk_prev_q, clk_prev_d;
  logic                  fall;

  state_e                state_q, state_d;
  logic [2:0]            bitcnt_q, bitcnt_d;
  logic [7:0]            sh_q, sh_d;
  logic                  par_q, par_d;
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic                  commit_q, commit_d;
  logic                  brk_q, brk_d;
  logic                  perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;

  logic                  push;
  logic [KEY_W-1:0]      fifo_dout;
  logic                  fifo_empty, fifo_full;

  assign fall = clk_prev_q && !clk_filt_q;

  // Two-flop synchroniser, then a shift-register glitch filter with hysteresis.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], PS2_CLK};
    dat_sync_d  = {dat_sync_q[0], PS2_DATA};
    clk_shift_d = {clk_shift_q[FILTER_LEN-2:0], clk_sync_q[1]};
    dat_shift_d = {dat_shift_q[FILTER_LEN-2:0], dat_sync_q[1]};
    clk_filt_d  = clk_filt_q;
    dat_filt_d  = dat_filt_q;
    if (&clk_shift_q)       clk_filt_d = 1'b1;
    else if (~|clk_shift_q) clk_filt_d = 1'b0;
    if (&dat_shift_q)       dat_filt_d = 1'b1;
    else if (~|dat_shift_q) dat_filt_d = 1'b0;
    clk_prev_d  = clk_filt_q;
  end

  // Deframer FSM, timeout, commit of the finished code and error flags.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sh_d     = sh_q;
    par_d    = par_q;
    to_cnt_d = '0;
    commit_d = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    brk_d    = brk_q;
    ovf_d    = ovf_q;

    if (fall) begin
      unique case (state_q)
        IDLE: if (!dat_filt_q) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
        DATA: begin
          sh_d     = {dat_filt_q, sh_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_filt_q;
          state_d = STOP;
        end
        STOP: begin
          if (odd_parity_ok(sh_q, par_q) && dat_filt_q) commit_d = 1'b1;
          else                                          perr_d   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d  = IDLE;
        bitcnt_d = '0;
        sh_d     = '0;
        ferr_d   = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end

    // The break prefix only arms the flag; any other code consumes it.
    push = commit_q && (sh_q != PS2_BREAK);
    if (commit_q) brk_d = (sh_q == PS2_BREAK);

    if (iClearErr) ovf_d = 1'b0;
    if (push && fifo_full && !iPop) ovf_d = 1'b1;
  end

  // All receiver state registers; lines idle high out of reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clk_sync_q  <= '1;
      dat_sync_q  <= '1;
      clk_shift_q <= '1;
      dat_shift_q <= '1;
      clk_filt_q  <= 1'b1;
      dat_filt_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      sh_q        <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      commit_q    <= 1'b0;
      brk_q       <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      clk_shift_q <= clk_shift_d;
      dat_shift_q <= dat_shift_d;
      clk_filt_q  <= clk_filt_d;
      dat_filt_q  <= dat_filt_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      sh_q        <= sh_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      commit_q    <= commit_d;
      brk_q       <= brk_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovf_q       <= ovf_d;
    end
  end

  scancode_fifo #(
    .DW(KEY_W),
    .AW(FIFO_AW)
  ) u_fifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (push),
    .pop   (iPop),
    .din   ({brk_q, sh_q}),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign oValid     = !fifo_empty;
  assign oKey       = fifo_empty ? '0 : fifo_dout;
  assign oParityErr = perr_q;
  assign oFrameErr  = ferr_q;
  assign oOverflow  = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed bench for the PS/2 scancode receiver. The PS/2 clock is scaled
// down to 80 system cycles per bit and the timeout to 2000 cycles so the
// whole run stays short; the relationships between them are preserved.
module tb_ps2_scancode_receiver;

  localparam int HALF    = 40;
  localparam int TIMEOUT = 2000;

  logic       Clock = 1'b0;
  logic       Reset, PS2_CLK, PS2_DATA, iPop, iClearErr;
  logic [8:0] oKey;
  logic       oValid, oParityErr, oFrameErr, oOverflow;

  int checks = 0;
  int errors = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;

  ps2_scancode_receiver #(
    .FILTER_LEN (8),
    .FIFO_AW    (2),
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .PS2_CLK   (PS2_CLK),
    .PS2_DATA  (PS2_DATA),
    .iPop      (iPop),
    .iClearErr (iClearErr),
    .oKey      (oKey),
    .oValid    (oValid),
    .oParityErr(oParityErr),
    .oFrameErr (oFrameErr),
    .oOverflow (oOverflow)
  );

  always #10 Clock = ~Clock;

  // Count error pulses, sampled away from the active edge.
  always @(negedge Clock) begin
    if (oParityErr === 1'b1) perr_cnt++;
    if (oFrameErr === 1'b1)  ferr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Data changes mid-high, then one full low/high PS/2 clock period.
  task automatic send_bit(input logic b);
    PS2_DATA = b;
    cycles(HALF / 2);
    PS2_CLK = 1'b0;
    cycles(HALF);
    PS2_CLK = 1'b1;
    cycles(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic flip_p, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit((~^code) ^ flip_p);
    send_bit(stop);
    PS2_DATA = 1'b1;
    cycles(HALF);
  endtask

  task automatic pop_check(input string tag, input logic [8:0] exp);
    @(negedge Clock);
    check({tag, "_valid"}, 32'(oValid), 32'd1);
    check(tag, 32'(oKey), 32'(exp));
    iPop = 1'b1;
    @(negedge Clock);
    iPop = 1'b0;
  endtask

  initial begin
    int p0, f0;
    Reset = 1'b1; PS2_CLK = 1'b1; PS2_DATA = 1'b1; iPop = 1'b0; iClearErr = 1'b0;
    cycles(5);
    check("rst_key", 32'(oKey), 32'h0);
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_perr", 32'(oParityErr), 32'd0);
    check("rst_ferr", 32'(oFrameErr), 32'd0);
    check("rst_ovf", 32'(oOverflow), 32'd0);
    Reset = 1'b0;
    cycles(20);

    // Single make code, then pop it.
    send_frame(8'h1C, 1'b0, 1'b1);
    pop_check("t1_key", 9'h01C);
    cycles(2);
    check("t1_empty", 32'(oValid), 32'd0);

    // Break prefix folds into the following code only.
    send_frame(8'hF0, 1'b0, 1'b1);
    check("t2_f0_nopush", 32'(oValid), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b1);
    pop_check("t2_break", 9'h11C);
    cycles(2);
    check("t2_single", 32'(oValid), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b1);
    pop_check("t2_make", 9'h01C);

    // Bad parity and bad stop each drop the frame with one pulse.
    p0 = perr_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    check("t3_parity", 32'(perr_cnt - p0), 32'd1);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t3_stop", 32'(perr_cnt - p0), 32'd2);
    check("t3_empty", 32'(oValid), 32'd0);

    // Partial frame aborted by timeout, then a clean frame.
    f0 = ferr_cnt;
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    PS2_DATA = 1'b1;
    cycles(3 * TIMEOUT / 2);
    check("t4_timeout", 32'(ferr_cnt - f0), 32'd1);
    check("t4_empty", 32'(oValid), 32'd0);
    send_frame(8'h32, 1'b0, 1'b1);
    pop_check("t4_recover", 9'h032);
    check("t4_no_perr", 32'(perr_cnt - p0), 32'd2);

    // Five codes into a four-entry FIFO.
    send_frame(8'h15, 1'b0, 1'b1);
    send_frame(8'h1D, 1'b0, 1'b1);
    send_frame(8'h24, 1'b0, 1'b1);
    send_frame(8'h2D, 1'b0, 1'b1);
    check("t5_no_ovf_yet", 32'(oOverflow), 32'd0);
    send_frame(8'h2C, 1'b0, 1'b1);
    check("t5_ovf", 32'(oOverflow), 32'd1);
    pop_check("t5_pop0", 9'h015);
    pop_check("t5_pop1", 9'h01D);
    pop_check("t5_pop2", 9'h024);
    pop_check("t5_pop3", 9'h02D);
    cycles(2);
    check("t5_empty", 32'(oValid), 32'd0);
    check("t5_sticky", 32'(oOverflow), 32'd1);
    iClearErr = 1'b1;
    cycles(1);
    iClearErr = 1'b0;
    cycles(1);
    check("t5_clear", 32'(oOverflow), 32'd0);

    // A short low glitch on the clock with data low must not start a frame.
    PS2_DATA = 1'b0;
    cycles(5);
    PS2_CLK = 1'b0;
    cycles(3);
    PS2_CLK = 1'b1;
    cycles(20);
    PS2_DATA = 1'b1;
    cycles(20);
    send_frame(8'h1C, 1'b0, 1'b1);
    pop_check("t6_glitch", 9'h01C);
    check("t6_glitch_perr", 32'(perr_cnt - p0), 32'd2);

    // Reset mid-frame empties the FIFO and discards the partial frame.
    send_frame(8'h2C, 1'b0, 1'b1);
    check("t6_pre_rst_valid", 32'(oValid), 32'd1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    f0 = ferr_cnt;
    Reset = 1'b1;
    PS2_DATA = 1'b1;
    cycles(3);
    check("t6_rst_valid", 32'(oValid), 32'd0);
    check("t6_rst_key", 32'(oKey), 32'h0);
    Reset = 1'b0;
    cycles(2 * TIMEOUT / 2 + 100);
    check("t6_rst_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("t6_rst_no_perr", 32'(perr_cnt - p0), 32'd2);
    send_frame(8'h1C, 1'b0, 1'b1);
    pop_check("t6_after_rst", 9'h01C);
    cycles(2);
    check("t6_final_empty", 32'(oValid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
